// File: rtl/if_fetch_stage_pkg.sv
// Shared pipeline constants for the instruction-fetch stage.
package if_fetch_stage_pkg;

  localparam int unsigned PIPE_PC_W    = 64;
  localparam int unsigned PIPE_INST_W  = 32;
  localparam int unsigned PIPE_IMEM_AW = 10;
  localparam int unsigned INST_BYTES   = 4;
  localparam int unsigned CNT_W        = 32;

  localparam logic [PIPE_PC_W-1:0]   PIPE_RESET_PC = 64'h0;
  localparam logic [PIPE_INST_W-1:0] NOP_INST      = 32'h0000_0013;

endpackage

// File: rtl/fetch_hold_buf.sv
// Holds one fetched word and its PC while the decode stage is stalled.
module fetch_hold_buf
  import if_fetch_stage_pkg::*;
#(
  parameter int unsigned        INST_W   = PIPE_INST_W,
  parameter int unsigned        PC_W     = PIPE_PC_W,
  parameter logic [PC_W-1:0]    RESET_PC = PC_W'(PIPE_RESET_PC)
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              capture,
  input  logic              clear,
  input  logic [INST_W-1:0] inst_d,
  input  logic [PC_W-1:0]   pc_d,
  output logic              hold,
  output logic [INST_W-1:0] hold_inst,
  output logic [PC_W-1:0]   hold_pc
);

  // Clear wins over capture; the payload only changes on capture.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      hold      <= 1'b0;
      hold_inst <= '0;
      hold_pc   <= RESET_PC;
    end else if (clear) begin
      hold      <= 1'b0;
    end else if (capture) begin
      hold      <= 1'b1;
      hold_inst <= inst_d;
      hold_pc   <= pc_d;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem request, redirect and stall hold.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter int unsigned     PC_W     = PIPE_PC_W,
  parameter int unsigned     INST_W   = PIPE_INST_W,
  parameter int unsigned     IMEM_AW  = PIPE_IMEM_AW,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(PIPE_RESET_PC)
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               en,
  input  logic               stall_i,
  input  logic               membranch_i,
  input  logic               zero_i,
  input  logic               memjump_i,
  input  logic [PC_W-1:0]    branchpc_i,
  input  logic [PC_W-1:0]    jumppc_i,
  output logic               imem_req_o,
  output logic [IMEM_AW-1:0] imem_addr_o,
  input  logic [INST_W-1:0]  imem_rdata_i,
  output logic [INST_W-1:0]  inst_o,
  output logic [PC_W-1:0]    pc_o,
  output logic               valid_o,
  output logic               flush_o,
  output logic               misalign_o,
  output logic [CNT_W-1:0]   fetch_cnt_o
);

  logic [PC_W-1:0]   pc;
  logic              pend;
  logic [PC_W-1:0]   pend_pc;
  logic              hold;
  logic [INST_W-1:0] hold_inst;
  logic [PC_W-1:0]   hold_pc;

  logic              redirect_c;
  logic [PC_W-1:0]   target_c;
  logic              issue_c;
  logic              capture_c;
  logic              clear_c;
  logic              accept_c;

  // Redirect decode, request issue and hold-buffer control.
  always_comb begin
    redirect_c = en & (memjump_i | (membranch_i & zero_i));
    target_c   = memjump_i ? jumppc_i : branchpc_i;
    issue_c    = en & ~stall_i & ~redirect_c & ~hold;
    // With en low the in-flight word is still parked so it is not lost.
    capture_c  = pend & ~hold & (en ? (stall_i & ~redirect_c) : 1'b1);
    clear_c    = en & (redirect_c | (~stall_i & hold));
    accept_c   = en & valid_o & ~stall_i;
  end

  // Outputs toward imem and IF/ID; the request is held off while in reset.
  always_comb begin
    imem_req_o  = issue_c & arst_n;
    imem_addr_o = pc[IMEM_AW+1:2];
    inst_o      = hold ? hold_inst : (pend ? imem_rdata_i : '0);
    pc_o        = hold ? hold_pc : pend_pc;
    valid_o     = (hold | pend) & ~redirect_c;
    flush_o     = redirect_c;
  end

  // PC and outstanding-request tracking.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pc      <= RESET_PC;
      pend    <= 1'b0;
      pend_pc <= RESET_PC;
    end else if (en) begin
      if (redirect_c) begin
        pc   <= {target_c[PC_W-1:2], 2'b00};
        pend <= 1'b0;
      end else if (issue_c) begin
        pc      <= pc + PC_W'(INST_BYTES);
        pend    <= 1'b1;
        pend_pc <= pc;
      end else begin
        pend <= 1'b0;
      end
    end
  end

  // Sticky misaligned-target flag and accepted-instruction counter.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      misalign_o  <= 1'b0;
      fetch_cnt_o <= '0;
    end else begin
      if (redirect_c && (target_c[1:0] != 2'b00)) begin
        misalign_o <= 1'b1;
      end
      if (accept_c) begin
        fetch_cnt_o <= fetch_cnt_o + CNT_W'(1);
      end
    end
  end

  fetch_hold_buf #(
    .INST_W   (INST_W),
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_hold_buf (
    .clk       (clk),
    .arst_n    (arst_n),
    .capture   (capture_c),
    .clear     (clear_c),
    .inst_d    (imem_rdata_i),
    .pc_d      (pend_pc),
    .hold      (hold),
    .hold_inst (hold_inst),
    .hold_pc   (hold_pc)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: stimulus queues expected PCs, monitor checks accepts.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        en = 1'b0;
  logic        stall_i = 1'b0;
  logic        membranch_i = 1'b0;
  logic        zero_i = 1'b0;
  logic        memjump_i = 1'b0;
  logic [63:0] branchpc_i = '0;
  logic [63:0] jumppc_i = '0;
  logic        imem_req_o;
  logic [9:0]  imem_addr_o;
  logic [31:0] imem_rdata_i = '0;
  logic [31:0] inst_o;
  logic [63:0] pc_o;
  logic        valid_o;
  logic        flush_o;
  logic        misalign_o;
  logic [31:0] fetch_cnt_o;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] exp_q[$];

  if_fetch_stage dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .en           (en),
    .stall_i      (stall_i),
    .membranch_i  (membranch_i),
    .zero_i       (zero_i),
    .memjump_i    (memjump_i),
    .branchpc_i   (branchpc_i),
    .jumppc_i     (jumppc_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_rdata_i (imem_rdata_i),
    .inst_o       (inst_o),
    .pc_o         (pc_o),
    .valid_o      (valid_o),
    .flush_o      (flush_o),
    .misalign_o   (misalign_o),
    .fetch_cnt_o  (fetch_cnt_o)
  );

  always #5 clk = ~clk;

  // Instruction memory model: word k holds k, one-cycle read latency.
  always @(posedge clk) begin
    if (imem_req_o) imem_rdata_i <= 32'(imem_addr_o);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, 64'(valid_o), 64'd0);
    chk({tag, "_inst"}, 64'(inst_o), 64'd0);
    chk({tag, "_pc"}, pc_o, 64'd0);
    chk({tag, "_flush"}, 64'(flush_o), 64'd0);
    chk({tag, "_misalign"}, 64'(misalign_o), 64'd0);
    chk({tag, "_cnt"}, 64'(fetch_cnt_o), 64'd0);
    chk({tag, "_req"}, 64'(imem_req_o), 64'd0);
  endtask

  // Monitor: every accepted instruction must match the head of the expected queue.
  always @(negedge clk) begin
    logic [63:0] e;
    if (arst_n && en && valid_o && !stall_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_accept actual_pc=%0h expected=none", pc_o);
      end else begin
        e = exp_q.pop_front();
        chk("accept_pc", pc_o, e);
        chk("accept_inst", 64'(inst_o), 64'(e[11:2]));
      end
    end
  end

  initial begin
    // Expected accepted PCs up to the mid-stall reset.
    exp_q.push_back(64'h00); exp_q.push_back(64'h04); exp_q.push_back(64'h08);
    exp_q.push_back(64'h0C); exp_q.push_back(64'h40); exp_q.push_back(64'h20);
    exp_q.push_back(64'h44);

    en = 1'b1;
    repeat (2) @(posedge clk);
    mid();
    chk_reset("rst0");

    // Sequential fetch
    tick(); arst_n = 1'b1;
    mid(); chk("c1_req", 64'(imem_req_o), 64'd1); chk("c1_addr", 64'(imem_addr_o), 64'd0);
    chk("c1_valid", 64'(valid_o), 64'd0);
    tick();
    mid(); chk("c2_addr", 64'(imem_addr_o), 64'd1); chk("c2_valid", 64'(valid_o), 64'd1);
    tick();
    mid(); chk("c3_cnt", 64'(fetch_cnt_o), 64'd1); chk("c3_addr", 64'(imem_addr_o), 64'd2);

    // Stall three cycles while 0x8 is presented
    tick(); stall_i = 1'b1;
    mid(); chk("c4_pc", pc_o, 64'h08); chk("c4_req", 64'(imem_req_o), 64'd0);
    chk("c4_cnt", 64'(fetch_cnt_o), 64'd2);
    for (int i = 0; i < 2; i++) begin
      tick();
      mid(); chk("stall_pc", pc_o, 64'h08); chk("stall_inst", 64'(inst_o), 64'd2);
      chk("stall_valid", 64'(valid_o), 64'd1); chk("stall_req", 64'(imem_req_o), 64'd0);
    end
    tick(); stall_i = 1'b0;
    mid(); chk("rel_pc", pc_o, 64'h08); chk("rel_req", 64'(imem_req_o), 64'd0);
    tick();
    mid(); chk("rel1_valid", 64'(valid_o), 64'd0); chk("rel1_req", 64'(imem_req_o), 64'd1);
    chk("rel1_addr", 64'(imem_addr_o), 64'd3);
    tick();
    mid(); chk("rel2_pc", pc_o, 64'h0C);

    // Jump has priority over taken branch
    tick(); memjump_i = 1'b1; jumppc_i = 64'h40; membranch_i = 1'b1; zero_i = 1'b1;
    branchpc_i = 64'h80;
    mid(); chk("jmp_flush", 64'(flush_o), 64'd1); chk("jmp_valid", 64'(valid_o), 64'd0);
    chk("jmp_req", 64'(imem_req_o), 64'd0);
    tick(); memjump_i = 1'b0; membranch_i = 1'b0; zero_i = 1'b0;
    mid(); chk("jmp1_flush", 64'(flush_o), 64'd0); chk("jmp1_addr", 64'(imem_addr_o), 64'h10);
    chk("jmp1_req", 64'(imem_req_o), 64'd1);
    tick();
    mid(); chk("jmp2_pc", pc_o, 64'h40);

    // Taken branch while stalled with the hold buffer full
    tick(); stall_i = 1'b1;
    mid(); chk("hs_pc", pc_o, 64'h44);
    tick(); membranch_i = 1'b1; zero_i = 1'b1; branchpc_i = 64'h20;
    mid(); chk("br_flush", 64'(flush_o), 64'd1); chk("br_valid", 64'(valid_o), 64'd0);
    tick(); membranch_i = 1'b0; zero_i = 1'b0; stall_i = 1'b0;
    mid(); chk("br1_valid", 64'(valid_o), 64'd0); chk("br1_addr", 64'(imem_addr_o), 64'd8);
    tick();
    mid(); chk("br2_pc", pc_o, 64'h20);

    // Misaligned jump target
    tick(); memjump_i = 1'b1; jumppc_i = 64'h46;
    mid(); chk("mis_flush", 64'(flush_o), 64'd1); chk("mis_pre", 64'(misalign_o), 64'd0);
    tick(); memjump_i = 1'b0;
    mid(); chk("mis_flag", 64'(misalign_o), 64'd1); chk("mis_addr", 64'(imem_addr_o), 64'h11);
    tick();
    mid(); chk("mis_pc", pc_o, 64'h44); chk("mis_inst", 64'(inst_o), 64'h11);

    // Async reset mid-stall with hold full
    tick(); stall_i = 1'b1;
    mid(); chk("pre_rst_pc", pc_o, 64'h48);
    tick();
    mid(); chk("pre_rst_cnt", 64'(fetch_cnt_o), 64'd7); chk("pre_rst_mis", 64'(misalign_o), 64'd1);
    chk("pre_rst_valid", 64'(valid_o), 64'd1);
    chk("queue_drained_1", 64'(exp_q.size()), 64'd0);
    #1 arst_n = 1'b0;
    #1 chk_reset("rst1");
    stall_i = 1'b0;
    exp_q.push_back(64'h00); exp_q.push_back(64'h04);
    exp_q.push_back(64'h08); exp_q.push_back(64'h0C);

    tick(); arst_n = 1'b1;
    mid(); chk("r_req", 64'(imem_req_o), 64'd1); chk("r_addr", 64'(imem_addr_o), 64'd0);
    tick();
    mid(); chk("r_pc0", pc_o, 64'h00);
    tick();
    mid(); chk("r_pc4", pc_o, 64'h04);

    // Enable low: freeze, but park the in-flight word
    tick(); en = 1'b0;
    mid(); chk("en0_req", 64'(imem_req_o), 64'd0); chk("en0_pc", pc_o, 64'h08);
    tick();
    mid(); chk("en0b_inst", 64'(inst_o), 64'd2); chk("en0b_cnt", 64'(fetch_cnt_o), 64'd2);
    chk("en0b_req", 64'(imem_req_o), 64'd0);
    tick(); en = 1'b1;
    mid(); chk("en1_pc", pc_o, 64'h08); chk("en1_req", 64'(imem_req_o), 64'd0);
    tick();
    mid(); chk("en1b_addr", 64'(imem_addr_o), 64'd3); chk("en1b_cnt", 64'(fetch_cnt_o), 64'd3);
    tick();
    mid(); chk("en1c_pc", pc_o, 64'h0C);
    tick(); en = 1'b0;
    mid(); chk("end_cnt", 64'(fetch_cnt_o), 64'd4);
    tick();
    mid(); chk("queue_drained_2", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
